// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: PC register, IF/ID pipeline register with stall/flush/redirect,
// misaligned-redirect trap substitution and a count of delivered instructions.
module if_stage #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013,
    parameter int unsigned     CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             redirect_i,
    input  logic [XLEN-1:0]  redirect_pc_i,
    output logic [XLEN-1:0]  imem_addr_o,
    input  logic [XLEN-1:0]  imem_rd_i,
    output logic [XLEN-1:0]  instr_d_o,
    output logic [XLEN-1:0]  pc_d_o,
    output logic [XLEN-1:0]  pc_plus4_d_o,
    output logic             valid_d_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] fetch_count_o
);

    logic [XLEN-1:0]  r_pc, w_pc_next, w_pc_plus4;
    logic [XLEN-1:0]  r_instr, w_instr_next;
    logic [XLEN-1:0]  r_pc_d, w_pc_d_next;
    logic [XLEN-1:0]  r_pc4_d, w_pc4_d_next;
    logic             r_valid, w_valid_next;
    logic             r_misalign, w_misalign_next;
    logic [CNT_W-1:0] r_count, w_count_next;
    logic             w_bad_target;

    assign w_pc_plus4   = r_pc + XLEN'(4);
    assign w_bad_target = redirect_i && (redirect_pc_i[1:0] != 2'b00);

    always_comb begin
        w_pc_next       = w_pc_plus4;
        w_misalign_next = w_bad_target;
        if (redirect_i) begin
            w_pc_next = w_bad_target ? TRAP_VEC : redirect_pc_i;
        end else if (stall_i) begin
            w_pc_next = r_pc;
        end
    end

    // A redirect squashes the word fetched on the wrong path, so it bubbles IF/ID like a flush.
    always_comb begin
        w_instr_next = r_instr;
        w_pc_d_next  = r_pc_d;
        w_pc4_d_next = r_pc4_d;
        w_valid_next = r_valid;
        w_count_next = r_count;
        if (redirect_i || flush_i) begin
            w_instr_next = NOP_INSTR;
            w_pc_d_next  = '0;
            w_pc4_d_next = '0;
            w_valid_next = 1'b0;
        end else if (!stall_i) begin
            w_instr_next = imem_rd_i;
            w_pc_d_next  = r_pc;
            w_pc4_d_next = w_pc_plus4;
            w_valid_next = 1'b1;
            w_count_next = r_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_instr    <= NOP_INSTR;
            r_pc_d     <= '0;
            r_pc4_d    <= '0;
            r_valid    <= 1'b0;
            r_misalign <= 1'b0;
            r_count    <= '0;
        end else begin
            r_pc       <= w_pc_next;
            r_instr    <= w_instr_next;
            r_pc_d     <= w_pc_d_next;
            r_pc4_d    <= w_pc4_d_next;
            r_valid    <= w_valid_next;
            r_misalign <= w_misalign_next;
            r_count    <= w_count_next;
        end
    end

    assign imem_addr_o   = r_pc;
    assign instr_d_o     = r_instr;
    assign pc_d_o        = r_pc_d;
    assign pc_plus4_d_o  = r_pc4_d;
    assign valid_d_o     = r_valid;
    assign misalign_o    = r_misalign;
    assign fetch_count_o = r_count;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a reference model pushes expected post-edge state into a
// scoreboard queue that is popped and checked one step after the edge.
module tb_if_stage;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] TRAP = 32'h0000_0100;
    localparam logic [31:0] TAG  = 32'hA000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i, flush_i, redirect_i;
    logic [31:0] redirect_pc_i, imem_addr_o, imem_rd_i;
    logic [31:0] instr_d_o, pc_d_o, pc_plus4_d_o, fetch_count_o;
    logic        valid_d_o, misalign_o;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pcd;
        logic [31:0] pc4;
        logic        valid;
        logic        mis;
        logic [31:0] cnt;
    } state_t;

    state_t m;
    state_t sb_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;

    if_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_addr_o   (imem_addr_o),
        .imem_rd_i     (imem_rd_i),
        .instr_d_o     (instr_d_o),
        .pc_d_o        (pc_d_o),
        .pc_plus4_d_o  (pc_plus4_d_o),
        .valid_d_o     (valid_d_o),
        .misalign_o    (misalign_o),
        .fetch_count_o (fetch_count_o)
    );

    always #5 clk = ~clk;

    // Instruction memory: combinational, word tagged with its address, zero during reset.
    always_comb imem_rd_i = reset ? 32'h0 : ({imem_addr_o[31:2], 2'b00} | TAG);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m = '{pc: 32'h0, instr: NOP, pcd: 32'h0, pc4: 32'h0, valid: 1'b0, mis: 1'b0, cnt: 32'h0};
    endtask

    task automatic check_all(input string tag, input state_t e);
        chk({tag, ".pc"}, imem_addr_o, e.pc);
        chk({tag, ".instr"}, instr_d_o, e.instr);
        chk({tag, ".pc_d"}, pc_d_o, e.pcd);
        chk({tag, ".pc4_d"}, pc_plus4_d_o, e.pc4);
        chk({tag, ".valid"}, {31'b0, valid_d_o}, {31'b0, e.valid});
        chk({tag, ".mis"}, {31'b0, misalign_o}, {31'b0, e.mis});
        chk({tag, ".cnt"}, fetch_count_o, e.cnt);
    endtask

    // Drive one cycle of controls, predict the post-edge state, then check it after the edge.
    task automatic step(input string tag, input logic st, input logic fl, input logic rd,
                        input logic [31:0] rpc);
        state_t n;
        state_t e;
        stall_i = st; flush_i = fl; redirect_i = rd; redirect_pc_i = rpc;
        n = m;
        n.mis = rd && (rpc[1:0] != 2'b00);
        if (rd) n.pc = (rpc[1:0] != 2'b00) ? TRAP : rpc;
        else if (!st) n.pc = m.pc + 32'd4;
        if (rd || fl) begin
            n.instr = NOP; n.pcd = 32'h0; n.pc4 = 32'h0; n.valid = 1'b0;
        end else if (!st) begin
            n.instr = m.pc | TAG; n.pcd = m.pc; n.pc4 = m.pc + 32'd4; n.valid = 1'b1;
            n.cnt = m.cnt + 32'd1;
        end
        sb_q.push_back(n);
        m = n;
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_all(tag, e);
    endtask

    initial begin
        reset = 1'b1;
        stall_i = 1'b0; flush_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", m);
        reset = 1'b0;

        step("free0", 0, 0, 0, 32'h0);
        chk("cap0.instr", instr_d_o, 32'hA000_0000);
        step("free1", 0, 0, 0, 32'h0);
        chk("pc_is_8", imem_addr_o, 32'h8);
        step("stall0", 1, 0, 0, 32'h0);
        step("stall1", 1, 0, 0, 32'h0);
        chk("stall.pc_held", imem_addr_o, 32'h8);
        step("resume", 0, 0, 0, 32'h0);
        chk("resume.pc_d", pc_d_o, 32'h8);
        chk("resume.cnt", fetch_count_o, 32'd3);
        step("free2", 0, 0, 0, 32'h0);
        chk("pc_is_10", imem_addr_o, 32'h10);

        step("redir_stall", 1, 0, 1, 32'h40);
        chk("redir.pc", imem_addr_o, 32'h40);
        chk("redir.instr", instr_d_o, NOP);
        step("after_redir", 0, 0, 0, 32'h0);
        chk("after_redir.pc_d", pc_d_o, 32'h40);

        step("misal", 0, 0, 1, 32'h42);
        chk("misal.pc", imem_addr_o, TRAP);
        chk("misal.pulse", {31'b0, misalign_o}, 32'h1);
        step("misal_end", 0, 0, 0, 32'h0);
        chk("misal_end.pulse", {31'b0, misalign_o}, 32'h0);
        step("misal_b2b0", 0, 0, 1, 32'h43);
        step("misal_b2b1", 1, 0, 1, 32'h81);
        step("misal_b2b_end", 0, 0, 0, 32'h0);

        step("to_20", 0, 0, 1, 32'h20);
        step("flush_stall", 1, 1, 0, 32'h0);
        chk("flush_stall.pc", imem_addr_o, 32'h20);
        step("after_fs", 0, 0, 0, 32'h0);
        chk("after_fs.pc_d", pc_d_o, 32'h20);
        step("flush_only", 0, 1, 0, 32'h0);

        step("to_top", 0, 0, 1, 32'hFFFF_FFFC);
        step("wrap", 0, 0, 0, 32'h0);
        chk("wrap.pc", imem_addr_o, 32'h0);
        chk("wrap.pc4_d", pc_plus4_d_o, 32'h0);
        step("post_wrap", 0, 0, 0, 32'h0);
        chk("post_wrap.pc_d", pc_d_o, 32'h0);

        // Asynchronous reset landing mid-cycle while a redirect is being driven.
        stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst", m);
        @(posedge clk);
        #1;
        check_all("rst_hold", m);
        stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
        reset = 1'b0;
        step("first_after_rst", 0, 0, 0, 32'h0);
        chk("first.valid", {31'b0, valid_d_o}, 32'h1);
        chk("first.cnt", fetch_count_o, 32'd1);
        step("second_after_rst", 0, 0, 0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
